simon_round_ctrl: RTL
=====================

// Module: simon_round_ctrl
// PURPOSE
//  Sequencing controller for the SIMON encryption core. It sits between the packet
//  front end (newKEY/newDATA producer) and the round datapath / key schedule.
//  - Acknowledges key and data blocks with a four-phase handshake.
//  - Strobes the capture registers, runs exactly T rounds, then hands the result
//    to the output stage through a second four-phase handshake.
// PARAMETERS
//  N  16  word size in bits (informational; no datapath in this block)
//  M  4   key words (informational)
//  T  32  rounds per block, 1..255
// PORTS
//  clk       in   1  single clock; all logic on posedge
//  R         in   1  synchronous reset, active high
//  newKEY    in   1  front end holds a key block on KEY
//  newDATA   in   1  front end holds a data block on inDATA
//  loadOUT   in   1  output stage has taken the result
//  loadKEY   out  1  key handshake acknowledge
//  loadDATA  out  1  data handshake acknowledge
//  keyLD     out  1  one-cycle strobe: master key register <= KEY
//  dataLD    out  1  one-cycle strobe: data register <= inDATA
//  keyRST    out  1  one-cycle strobe: round-key pipeline <= master key
//  roundEN   out  1  datapath performs one round this cycle
//  keyEN     out  1  key schedule advances this cycle (== roundEN)
//  round     out  8  index of the current round, 0..T-1
//  newOUT    out  1  result valid, output handshake request
//  keyVALID  out  1  a master key has been loaded since reset
//  busy      out  1  state != IDLE
// BEHAVIOUR
//  - All outputs are registered Moore outputs.
//  - On R: state=IDLE, round=0, keyVALID=0; every strobe, ack, newOUT and busy are 0.
//    R has priority in any state; it aborts any handshake or run mid-operation.
//  - States: IDLE, KACK, DACK, PREP, RUN, OREQ, OREL.
//  - IDLE:
//    - newKEY=1 -> KACK. newKEY has priority when newKEY and newDATA are high together.
//    - newDATA=1 && keyVALID=1 (and newKEY=0) -> DACK.
//    - newDATA=1 && keyVALID=0: no response; stay in IDLE and leave newDATA pending.
//  - KACK: loadKEY=1. keyLD=1 only in the first KACK cycle.
//    - Stay while newKEY=1.
//    - On newKEY=0 -> IDLE with keyVALID=1; loadKEY falls in the same edge.
//  - DACK: loadDATA=1. dataLD=1 only in the first DACK cycle.
//    - Stay while newDATA=1. On newDATA=0 -> PREP.
//  - PREP: exactly one cycle with keyRST=1 and round=0 -> RUN.
//  - RUN: exactly T cycles with roundEN=keyEN=1; round steps 0,1,...,T-1.
//    - In the cycle with round==T-1 -> OREQ; round returns to 0.
//    - round never wraps inside a run.
//  - OREQ: newOUT=1 until loadOUT=1, then -> OREL with newOUT=0.
//  - OREL: wait for loadOUT=0, then -> IDLE.
//  - newKEY or newDATA that rises outside IDLE stays pending and is served in IDLE.
//    A key change can therefore never corrupt a running block.
//  - Latency:
//    - newDATA rise to loadDATA: 1 cycle.
//    - newDATA fall to first roundEN: 2 cycles (the PREP cycle).
//    - Last roundEN to newOUT: 1 cycle.
//  - Any loadOUT seen outside OREQ/OREL is ignored.
// TESTING
//  1. Assert R for 2 clk. Sample during and after -> all outputs 0, round=0.
//  2. Key: newKEY=1 at cycle 0, held 3 cycles, then dropped.
//     -> loadKEY=1 in cycles 1..3; keyLD only in cycle 1; loadKEY=0 and keyVALID=1 from cycle 4.
//  3. Data with key loaded (T=32): newDATA pulse.
//     -> dataLD once; keyRST once; roundEN high 32 consecutive cycles with round 0..31.
//     -> newOUT rises next; dropping it needs loadOUT=1; return to IDLE needs loadOUT=0.
//  4. Data before any key: newDATA=1 after reset -> no loadDATA.
//     Then assert newKEY -> key served first, then data served automatically.
//  5. newKEY and newDATA rise in the same IDLE cycle -> KACK first, then DACK.
//     Also: newKEY raised during RUN round 10 -> no loadKEY until after OREL.
//  6. R=1 during RUN round 15 -> next cycle IDLE, roundEN=0, keyVALID=0.
//     Then newDATA alone is ignored.

Source files
------------

// File: rtl/simon_round_ctrl_if.sv
// Handshake and control bundle between the SIMON sequencer and its neighbours.
// The slave side is the sequencer; the master side is the front end, datapath and output stage.
interface simon_round_ctrl_if;
    logic       newKEY;
    logic       newDATA;
    logic       loadOUT;
    logic       loadKEY;
    logic       loadDATA;
    logic       keyLD;
    logic       dataLD;
    logic       keyRST;
    logic       roundEN;
    logic       keyEN;
    logic [7:0] round;
    logic       newOUT;
    logic       keyVALID;
    logic       busy;

    modport master (
        output newKEY, newDATA, loadOUT,
        input  loadKEY, loadDATA, keyLD, dataLD, keyRST, roundEN, keyEN,
        input  round, newOUT, keyVALID, busy
    );

    modport slave (
        input  newKEY, newDATA, loadOUT,
        output loadKEY, loadDATA, keyLD, dataLD, keyRST, roundEN, keyEN,
        output round, newOUT, keyVALID, busy
    );
endinterface

// File: rtl/simon_round_ctrl.sv
// Sequencing controller for the SIMON core: key/data acknowledge handshakes,
// capture strobes, a T-round run and the output request handshake.
module simon_round_ctrl #(
    parameter int N = 16,
    parameter int M = 4,
    parameter int T = 32
) (
    input  logic                     clk,
    input  logic                     R,
    simon_round_ctrl_if.slave        bus
);

    if (T < 1 || T > 255 || N < 1 || M < 1) begin : g_bad_param
        $error("simon_round_ctrl: T must be 1..255, N and M positive");
    end

    localparam logic [7:0] LAST_ROUND = 8'(T - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KACK,
        S_DACK,
        S_PREP,
        S_RUN,
        S_OREQ,
        S_OREL
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic       r_loadKEY,  w_loadKEY;
    logic       r_loadDATA, w_loadDATA;
    logic       r_keyLD,    w_keyLD;
    logic       r_dataLD,   w_dataLD;
    logic       r_keyRST,   w_keyRST;
    logic       r_roundEN,  w_roundEN;
    logic [7:0] r_round,    w_round;
    logic       r_newOUT,   w_newOUT;
    logic       r_keyVALID, w_keyVALID;
    logic       r_busy,     w_busy;

    // Every output is registered from the next state, so outputs change on the
    // same edge as the state they describe.
    always_ff @(posedge clk) begin
        if (R) begin
            r_state    <= S_IDLE;
            r_loadKEY  <= 1'b0;
            r_loadDATA <= 1'b0;
            r_keyLD    <= 1'b0;
            r_dataLD   <= 1'b0;
            r_keyRST   <= 1'b0;
            r_roundEN  <= 1'b0;
            r_round    <= 8'd0;
            r_newOUT   <= 1'b0;
            r_keyVALID <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_loadKEY  <= w_loadKEY;
            r_loadDATA <= w_loadDATA;
            r_keyLD    <= w_keyLD;
            r_dataLD   <= w_dataLD;
            r_keyRST   <= w_keyRST;
            r_roundEN  <= w_roundEN;
            r_round    <= w_round;
            r_newOUT   <= w_newOUT;
            r_keyVALID <= w_keyVALID;
            r_busy     <= w_busy;
        end
    end

    // Requests arriving outside IDLE are simply not looked at until IDLE,
    // so a key change cannot disturb a block in flight.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.newKEY)
                    w_next = S_KACK;
                else if (bus.newDATA && r_keyVALID)
                    w_next = S_DACK;
            end
            S_KACK: if (!bus.newKEY)           w_next = S_IDLE;
            S_DACK: if (!bus.newDATA)          w_next = S_PREP;
            S_PREP:                            w_next = S_RUN;
            S_RUN:  if (r_round == LAST_ROUND) w_next = S_OREQ;
            S_OREQ: if (bus.loadOUT)           w_next = S_OREL;
            S_OREL: if (!bus.loadOUT)          w_next = S_IDLE;
            default:                           w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_loadKEY  = (w_next == S_KACK);
        w_loadDATA = (w_next == S_DACK);
        w_keyLD    = (w_next == S_KACK) && (r_state != S_KACK);
        w_dataLD   = (w_next == S_DACK) && (r_state != S_DACK);
        w_keyRST   = (w_next == S_PREP);
        w_roundEN  = (w_next == S_RUN);
        w_newOUT   = (w_next == S_OREQ);
        w_busy     = (w_next != S_IDLE);
        w_keyVALID = r_keyVALID || ((r_state == S_KACK) && (w_next == S_IDLE));
        // Index counts only while staying in RUN; it is 0 on entry and after exit.
        w_round    = ((r_state == S_RUN) && (w_next == S_RUN)) ? r_round + 8'd1 : 8'd0;
    end

    assign bus.loadKEY  = r_loadKEY;
    assign bus.loadDATA = r_loadDATA;
    assign bus.keyLD    = r_keyLD;
    assign bus.dataLD   = r_dataLD;
    assign bus.keyRST   = r_keyRST;
    assign bus.roundEN  = r_roundEN;
    assign bus.keyEN    = r_roundEN;
    assign bus.round    = r_round;
    assign bus.newOUT   = r_newOUT;
    assign bus.keyVALID = r_keyVALID;
    assign bus.busy     = r_busy;

endmodule
